alu_arbiter: RTL and testbench

- Shares one instance of the team's combinational N-bit ALU between two requesters.
- The ALU covers add with carry, sll, srl, xor, or, not and and.
- Round-robin arbitration picks a requester; its operands are registered and driven to the ALU; the result and n/z/c/v flags are captured and returned on a valid/ready response channel tagged with the requester id.
- The block sits between the ALU and the bus-side masters; the ALU itself is instantiated outside.

---
 rtl/alu_arbiter.sv | 178 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// A round-robin arbiter picks a requester in IDLE, its operands are registered
// and drive the ALU during EXEC, and the ALU result/flags are captured and
// returned on a valid/ready response channel tagged with the requester id.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid[1:0]/req_ready   per-requester request handshake (ready is one-hot or zero)
//   req{0,1}_op/_a/_b/_cin     per-requester ALU control code, operands, carry-in
//   alu_a/alu_b/alu_control/alu_carryin  registered operands to the ALU
//   alu_result/alu_flags       ALU result and {n,z,c,v}
//   rsp_valid/rsp_ready        response handshake
//   rsp_id/rsp_result/rsp_flags  captured response payload
//   busy                       high while not IDLE
//   done_count                 completed responses, wraps
module alu_arbiter #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_control,
    output logic             alu_carryin,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             last_grant;
    logic             grant_valid_c;
    logic             grant_id_c;
    logic             accept_c;
    logic             rsp_fire_c;

    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cin_q;
    logic             id_q;

    // Round-robin arbitration: a tie goes to the requester that did not win last.
    always_comb begin
        grant_valid_c = 1'b0;
        grant_id_c    = 1'b0;
        case (req_valid)
            2'b01: begin
                grant_valid_c = 1'b1;
                grant_id_c    = 1'b0;
            end
            2'b10: begin
                grant_valid_c = 1'b1;
                grant_id_c    = 1'b1;
            end
            2'b11: begin
                grant_valid_c = 1'b1;
                grant_id_c    = ~last_grant;
            end
            default: begin
                grant_valid_c = 1'b0;
                grant_id_c    = 1'b0;
            end
        endcase
    end

    // Ready is combinational so a request is accepted in the cycle it is granted.
    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE && grant_valid_c) begin
            req_ready[grant_id_c] = 1'b1;
        end
    end

    assign accept_c   = (state == IDLE) && grant_valid_c;
    assign rsp_fire_c = (state == RESP) && rsp_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept_c) state_next = EXEC;
            EXEC: state_next = RESP;
            RESP: if (rsp_fire_c) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered status outputs track the next state so they align with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            busy      <= (state_next != IDLE);
            rsp_valid <= (state_next == RESP);
        end
    end

    // Operand capture on accept; these registers drive the ALU directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q       <= 3'd0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            id_q       <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept_c) begin
            op_q       <= grant_id_c ? req1_op  : req0_op;
            a_q        <= grant_id_c ? req1_a   : req0_a;
            b_q        <= grant_id_c ? req1_b   : req0_b;
            cin_q      <= grant_id_c ? req1_cin : req0_cin;
            id_q       <= grant_id_c;
            last_grant <= grant_id_c;
        end
    end

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_control = op_q;
    assign alu_carryin = cin_q;
    assign rsp_id      = id_q;

    // Result capture at the end of EXEC; held through RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_result <= '0;
            rsp_flags  <= 4'd0;
        end else if (state == EXEC) begin
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
        end
    end

    // Completed-response counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_count <= '0;
        end else if (rsp_fire_c) begin
            done_count <= done_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: table-driven single transactions, directed
// arbitration/backpressure/reset sequences, and a randomized run against a
// transaction-level reference model. A second instance with CNT_W=2 checks
// counter wrap.
module tb_alu_arbiter;

    localparam int unsigned W = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]   req_valid;
    logic [2:0]   p_op  [2];
    logic [W-1:0] p_a   [2];
    logic [W-1:0] p_b   [2];
    logic         p_cin [2];
    logic         rsp_ready;

    logic [1:0]   req_ready, req_ready2;
    logic [W-1:0] alu_a, alu_b, alu_result, alu_a2, alu_b2, alu_result2;
    logic [2:0]   alu_control, alu_control2;
    logic         alu_carryin, alu_carryin2;
    logic [3:0]   alu_flags, alu_flags2;
    logic         rsp_valid, rsp_valid2, rsp_id, rsp_id2, busy, busy2;
    logic [W-1:0] rsp_result, rsp_result2;
    logic [3:0]   rsp_flags, rsp_flags2;
    logic [7:0]   done_count;
    logic [1:0]   done_count2;

    int n_total = 0;
    int n_pass  = 0;

    // Reference ALU: returns {n,z,c,v, result}; v is not modelled (always 0).
    function automatic logic [W+3:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic cin);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c;
        s = '0; r = '0; c = 1'b0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
                r = s[W-1:0];
                c = s[W];
            end
            3'd1: r = a << b;
            3'd2: r = a >> b;
            3'd3: r = a ^ b;
            3'd4: r = a | b;
            3'd5: r = ~a;
            3'd6: r = a & b;
            default: r = '0;
        endcase
        return {r[W-1], (r == '0), c, 1'b0, r};
    endfunction

    assign {alu_flags,  alu_result}  = ref_alu(alu_control,  alu_a,  alu_b,  alu_carryin);
    assign {alu_flags2, alu_result2} = ref_alu(alu_control2, alu_a2, alu_b2, alu_carryin2);

    alu_arbiter #(.WIDTH(W), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_op(p_op[0]), .req0_a(p_a[0]), .req0_b(p_b[0]), .req0_cin(p_cin[0]),
        .req1_op(p_op[1]), .req1_a(p_a[1]), .req1_b(p_b[1]), .req1_cin(p_cin[1]),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_carryin(alu_carryin),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .busy(busy), .done_count(done_count)
    );

    alu_arbiter #(.WIDTH(W), .CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready2),
        .req0_op(p_op[0]), .req0_a(p_a[0]), .req0_b(p_b[0]), .req0_cin(p_cin[0]),
        .req1_op(p_op[1]), .req1_a(p_a[1]), .req1_b(p_b[1]), .req1_cin(p_cin[1]),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_control(alu_control2), .alu_carryin(alu_carryin2),
        .alu_result(alu_result2), .alu_flags(alu_flags2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_id(rsp_id2),
        .rsp_result(rsp_result2), .rsp_flags(rsp_flags2),
        .busy(busy2), .done_count(done_count2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic cin);
        p_op[i] = op; p_a[i] = a; p_b[i] = b; p_cin[i] = cin;
    endtask

    task automatic do_reset();
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
    endtask

    // Wait (bounded) for a response, accept it and return to an idle cycle.
    task automatic drain(input string nm);
        int n;
        rsp_ready = 1'b1;
        n = 0;
        while (!rsp_valid && n < 10) begin
            cyc();
            n++;
        end
        if (!rsp_valid) chk({nm, "_timeout"}, 32'(rsp_valid), 32'd1);
        cyc();
    endtask

    // Spec-level arbitration rule: -1 = no grant.
    function automatic int exp_grant(input logic [1:0] v, input logic last);
        if (v == 2'b00) return -1;
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        return last ? 0 : 1;
    endfunction

    typedef struct {
        logic         rq;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] er;
        logic [3:0]   ef;
    } vec_t;

    typedef struct {
        logic         id;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W+3:0] res;
    } exp_t;

    initial begin
        vec_t vt[9];
        logic [W-1:0] h_res;
        logic [3:0]   h_flg;
        int           grant;
        int           phase;
        logic         m_last;
        int           m_done;
        exp_t         m_exp;
        int           acc_id;
        int           acc_n, dn, last_acc, rv_seen;
        logic         hs_prev;
        int           dseq[5];

        set_req(0, 3'd0, '0, '0, 1'b0);
        set_req(1, 3'd0, '0, '0, 1'b0);

        // Reset state, sampled while reset is still asserted.
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done_count), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_ctl", 32'(alu_control), 32'd0);
        chk("rst_rsp_result", 32'(rsp_result), 32'd0);
        chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
        cyc();
        reset = 1'b0;
        cyc();

        // Single-transaction vectors with hand-derived ALU results.
        vt[0] = '{1'b0, 3'd0, 3'd3, 3'd2, 1'b1, 3'd6, 4'b1000};
        vt[1] = '{1'b1, 3'd5, 3'd2, 3'd0, 1'b0, 3'd5, 4'b1000};
        vt[2] = '{1'b0, 3'd3, 3'd5, 3'd3, 1'b0, 3'd6, 4'b1000};
        vt[3] = '{1'b1, 3'd6, 3'd4, 3'd3, 1'b0, 3'd0, 4'b0100};
        vt[4] = '{1'b0, 3'd0, 3'd7, 3'd1, 1'b0, 3'd0, 4'b0110};
        vt[5] = '{1'b1, 3'd1, 3'd3, 3'd1, 1'b0, 3'd6, 4'b1000};
        vt[6] = '{1'b0, 3'd2, 3'd6, 3'd2, 1'b0, 3'd1, 4'b0000};
        vt[7] = '{1'b1, 3'd4, 3'd1, 3'd2, 1'b0, 3'd3, 4'b0000};
        vt[8] = '{1'b0, 3'd7, 3'd5, 3'd5, 1'b1, 3'd0, 4'b0100};
        for (int i = 0; i < 9; i++) begin
            set_req(int'(vt[i].rq), vt[i].op, vt[i].a, vt[i].b, vt[i].cin);
            req_valid = vt[i].rq ? 2'b10 : 2'b01;
            rsp_ready = 1'b1;
            @(negedge clk);
            chk("vec_req_ready", 32'(req_ready), vt[i].rq ? 32'd2 : 32'd1);
            cyc();
            req_valid = 2'b00;
            @(negedge clk);
            chk("vec_exec_ctl", 32'(alu_control), 32'(vt[i].op));
            chk("vec_exec_a", 32'(alu_a), 32'(vt[i].a));
            chk("vec_exec_b", 32'(alu_b), 32'(vt[i].b));
            chk("vec_exec_cin", 32'(alu_carryin), 32'(vt[i].cin));
            chk("vec_exec_rsp_valid", 32'(rsp_valid), 32'd0);
            cyc();
            @(negedge clk);
            chk("vec_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("vec_rsp_id", 32'(rsp_id), 32'(vt[i].rq));
            chk("vec_rsp_result", 32'(rsp_result), 32'(vt[i].er));
            chk("vec_rsp_flags", 32'(rsp_flags), 32'(vt[i].ef));
            cyc();
            @(negedge clk);
            chk("vec_done", 32'(done_count), 32'(i + 1));
            chk("vec_idle_busy", 32'(busy), 32'd0);
            cyc();
        end

        // Both requesters valid: grants alternate starting at 0, 3-cycle spacing.
        do_reset();
        set_req(0, 3'd4, 3'd1, 3'd2, 1'b0);
        set_req(1, 3'd3, 3'd7, 3'd1, 1'b0);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        dseq = '{1, 2, 3, 0, 1};
        acc_n = 0; dn = 0; last_acc = -1; hs_prev = 1'b0;
        for (int t = 0; t < 60 && dn < 5; t++) begin
            @(negedge clk);
            if (hs_prev) begin
                chk("wrap_done2", 32'(done_count2), 32'(dseq[dn]));
                if (dn == 3) chk("alt_done4", 32'(done_count), 32'd4);
                dn++;
            end
            if (req_ready != 2'b00 && acc_n < 5) begin
                chk("alt_grant", 32'(req_ready), (acc_n % 2 == 1) ? 32'd2 : 32'd1);
                if (acc_n > 0) chk("alt_spacing", 32'(t - last_acc), 32'd3);
                last_acc = t;
                acc_n++;
            end
            hs_prev = rsp_valid & rsp_ready;
            cyc();
            if (acc_n >= 5) req_valid = 2'b00;
        end
        chk("alt_completed", 32'(dn), 32'd5);
        chk("alt_done5", 32'(done_count), 32'd5);

        // Backpressure: response held stable, no new accepts while waiting.
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        cyc();
        set_req(0, 3'd4, 3'd1, 3'd6, 1'b0);
        set_req(1, 3'd0, 3'd1, 3'd1, 1'b0);
        req_valid = 2'b01;
        @(negedge clk);
        chk("bp_accept", 32'(req_ready), 32'd1);
        cyc();
        req_valid = 2'b10;
        cyc();
        @(negedge clk);
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        h_res = rsp_result;
        h_flg = rsp_flags;
        chk("bp_result", 32'(h_res), 32'd7);
        chk("bp_flags", 32'(h_flg), 32'b1000);
        for (int k = 0; k < 5; k++) begin
            cyc();
            @(negedge clk);
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_hold_id", 32'(rsp_id), 32'd0);
            chk("bp_hold_result", 32'(rsp_result), 32'(h_res));
            chk("bp_hold_flags", 32'(rsp_flags), 32'(h_flg));
            chk("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        cyc();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_fire_valid", 32'(rsp_valid), 32'd1);
        cyc();
        @(negedge clk);
        chk("bp_after_valid", 32'(rsp_valid), 32'd0);
        chk("bp_next_accept", 32'(req_ready), 32'd2);
        cyc();
        req_valid = 2'b00;
        drain("bp");

        // Reset while in EXEC: operation discarded, state cleared at once.
        rsp_ready = 1'b1;
        set_req(0, 3'd0, 3'd2, 3'd2, 1'b0);
        req_valid = 2'b01;
        @(negedge clk);
        chk("rx_accept", 32'(req_ready), 32'd1);
        cyc();
        req_valid = 2'b00;
        #2;
        chk("rx_pre_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("rx_busy", 32'(busy), 32'd0);
        chk("rx_done", 32'(done_count), 32'd0);
        chk("rx_rsp_valid", 32'(rsp_valid), 32'd0);
        cyc();
        reset = 1'b0;
        rv_seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rsp_valid) rv_seen++;
            cyc();
        end
        chk("rx_no_rsp", 32'(rv_seen), 32'd0);
        set_req(1, 3'd6, 3'd7, 3'd5, 1'b0);
        req_valid = 2'b11;
        @(negedge clk);
        chk("rx_tie_req0", 32'(req_ready), 32'd1);
        cyc();
        req_valid = 2'b00;
        cyc();
        @(negedge clk);
        chk("rx_rsp_id", 32'(rsp_id), 32'd0);
        chk("rx_rsp_result", 32'(rsp_result), 32'd4);
        drain("rx");

        // Randomized run against the transaction-level model.
        do_reset();
        phase = 0; m_last = 1'b1; m_done = 0; acc_id = -1;
        m_exp = '{1'b0, 3'd0, '0, '0, 1'b0, '0};
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && acc_id != i) begin
                    if ($urandom_range(9) == 0) req_valid[i] = 1'b0;
                end else begin
                    set_req(i, 3'($urandom_range(7)), W'($urandom), W'($urandom), 1'($urandom));
                    req_valid[i] = ($urandom_range(2) != 0);
                end
            end
            rsp_ready = ($urandom_range(3) != 0);
            acc_id = -1;
            @(negedge clk);
            grant = (phase == 0) ? exp_grant(req_valid, m_last) : -1;
            chk("rnd_req_ready", 32'(req_ready), (grant < 0) ? 32'd0 : (32'd1 << grant));
            chk("rnd_req_ready2", 32'(req_ready2), (grant < 0) ? 32'd0 : (32'd1 << grant));
            chk("rnd_busy", 32'(busy), 32'(phase != 0));
            chk("rnd_rsp_valid", 32'(rsp_valid), 32'(phase == 2));
            chk("rnd_rsp_valid2", 32'(rsp_valid2), 32'(phase == 2));
            chk("rnd_done", 32'(done_count), 32'(m_done % 256));
            chk("rnd_done2", 32'(done_count2), 32'(m_done % 4));
            if (phase == 1) begin
                chk("rnd_alu_ctl", 32'(alu_control), 32'(m_exp.op));
                chk("rnd_alu_a", 32'(alu_a), 32'(m_exp.a));
                chk("rnd_alu_b", 32'(alu_b), 32'(m_exp.b));
                chk("rnd_alu_cin", 32'(alu_carryin), 32'(m_exp.cin));
            end
            if (phase == 2) begin
                chk("rnd_rsp_id", 32'(rsp_id), 32'(m_exp.id));
                chk("rnd_rsp_result", 32'(rsp_result), 32'(m_exp.res[W-1:0]));
                chk("rnd_rsp_flags", 32'(rsp_flags), 32'(m_exp.res[W+3:W]));
                chk("rnd_rsp_id2", 32'(rsp_id2), 32'(m_exp.id));
                chk("rnd_rsp_result2", 32'(rsp_result2), 32'(m_exp.res[W-1:0]));
                chk("rnd_rsp_flags2", 32'(rsp_flags2), 32'(m_exp.res[W+3:W]));
            end
            if (phase == 0 && grant >= 0) begin
                m_exp.id  = 1'(grant);
                m_exp.op  = p_op[grant];
                m_exp.a   = p_a[grant];
                m_exp.b   = p_b[grant];
                m_exp.cin = p_cin[grant];
                m_exp.res = ref_alu(p_op[grant], p_a[grant], p_b[grant], p_cin[grant]);
                m_last = 1'(grant);
                acc_id = grant;
                phase = 1;
            end else if (phase == 1) begin
                phase = 2;
            end else if (phase == 2 && rsp_ready) begin
                m_done++;
                phase = 0;
            end
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
